// File: rtl/board_mem_wb_slave.sv
// Wishbone pipelined slave holding the board state RAM, with a self-clearing sweep after reset and on clear_req.
// Optional macro BOARD_MEM_ERR_EN: out-of-range accepts answer on err_o instead of ack_i.
module board_mem_wb_slave #(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        DATA_W    = 16,
  parameter int unsigned        DEPTH     = 256,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] adr_o,
  input  logic [DATA_W-1:0] dat_o,
  input  logic              we_o,
  input  logic              stb_o,
  input  logic              cyc_o,
  output logic [DATA_W-1:0] dat_i,
  output logic              ack_i,
  output logic              stall_i,
`ifdef BOARD_MEM_ERR_EN
  output logic              err_o,
`endif
  input  logic              clear_req,
  output logic              clear_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic                accept;
  logic                in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state plus the single RAM write port, shared by the sweep and bus writes.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    accept      = cyc_o & stb_o & ~stall_i;
    in_range    = {1'b0, adr_o} < DEPTH_EXT;
    mem_we      = 1'b0;
    mem_wa      = adr_o;
    mem_wd      = dat_o;
    case (state)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_wa      = clr_cnt;
        mem_wd      = CLEAR_VAL;
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == LAST_ADDR) state_nxt = IDLE;
      end
      IDLE: begin
        mem_we = accept & we_o & in_range;
        if (clear_req) begin
          clr_cnt_nxt = '0;
          state_nxt   = CLEAR;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Registered bus response; dat_i only moves on an acked read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_i   <= 1'b0;
      dat_i   <= '0;
      stall_i <= 1'b1;
`ifdef BOARD_MEM_ERR_EN
      err_o   <= 1'b0;
`endif
    end else begin
      stall_i <= (state_nxt == CLEAR);
`ifdef BOARD_MEM_ERR_EN
      ack_i   <= accept & in_range;
      err_o   <= accept & ~in_range;
      if (accept & ~we_o & in_range) dat_i <= mem[adr_o];
`else
      ack_i   <= accept;
      if (accept & ~we_o) dat_i <= in_range ? mem[adr_o] : '0;
`endif
    end
  end

  assign clear_busy = stall_i;

endmodule

// File: tb/tb_board_mem_wb_slave.sv
// Self-checking bench for board_mem_wb_slave: a 256-word and a 200-word instance against array models.
module tb_board_mem_wb_slave;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we, cyc2, stb2, clear_req;
  logic [7:0]  adr;
  logic [15:0] wdat;
  logic [15:0] dat1, dat2;
  logic        ack1, ack2, stall1, stall2, busy1, busy2;
`ifdef BOARD_MEM_ERR_EN
  logic        err1, err2;
`endif

  int checks;
  int errors;
  logic [15:0] model1 [256];
  logic [15:0] model2 [200];
  logic [15:0] exp_dat1, exp_dat2;

  board_mem_wb_slave dut1 (
    .clk(clk), .rst_n(rst_n), .adr_o(adr), .dat_o(wdat), .we_o(we), .stb_o(stb), .cyc_o(cyc),
    .dat_i(dat1), .ack_i(ack1), .stall_i(stall1),
`ifdef BOARD_MEM_ERR_EN
    .err_o(err1),
`endif
    .clear_req(clear_req), .clear_busy(busy1)
  );

  board_mem_wb_slave #(.DEPTH(200)) dut2 (
    .clk(clk), .rst_n(rst_n), .adr_o(adr), .dat_o(wdat), .we_o(we), .stb_o(stb2), .cyc_o(cyc2),
    .dat_i(dat2), .ack_i(ack2), .stall_i(stall2),
`ifdef BOARD_MEM_ERR_EN
    .err_o(err2),
`endif
    .clear_req(clear_req), .clear_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle;
    cyc = 0; stb = 0; we = 0; cyc2 = 0; stb2 = 0;
  endtask

  task automatic clear_models;
    for (int i = 0; i < 256; i++) model1[i] = 16'h0000;
    for (int i = 0; i < 200; i++) model2[i] = 16'h0000;
  endtask

  // Counts negedge samples with stall high on each instance; optional extra clear_req mid-sweep.
  task automatic count_sweep(output int n1, output int n2, input int inject_at);
    n1 = 0; n2 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (stall1) n1++;
      if (stall2) n2++;
      if (!stall1 && !stall2) break;
      clear_req = (i == inject_at);
      @(negedge clk);
    end
    clear_req = 0;
  endtask

  task automatic test_reset;
    int n1, n2;
    rst_n = 0; clear_req = 0; adr = 0; wdat = 0;
    bus_idle();
    repeat (3) @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack1); end
    checks++; if (dat1 !== 16'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0000", dat1); end
    checks++; if (stall1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b/%b expected 1/1", stall1, busy1); end
    checks++; if (stall2 !== 1'b1 || ack2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: stall %b ack %b expected 1/0", stall2, ack2); end
`ifdef BOARD_MEM_ERR_EN
    checks++; if (err1 !== 1'b0 || err2 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b expected 0/0", err1, err2); end
`endif
    rst_n = 1;
    count_sweep(n1, n2, -1);
    checks++; if (n1 != 256) begin errors++; $display("FAIL reset_sweep_len: got %0d expected 256", n1); end
    checks++; if (n2 != 200) begin errors++; $display("FAIL reset_sweep_len2: got %0d expected 200", n2); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL busy_after_sweep: got %b expected 0", busy1); end
    clear_models();
    exp_dat1 = 16'h0; exp_dat2 = 16'h0;
  endtask

  task automatic test_read_after_reset;
    cyc = 1; stb = 1; we = 0; adr = 8'h37;
    @(negedge clk);
    bus_idle();
    exp_dat1 = model1[8'h37];
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL rd37_ack: got %b expected 1", ack1); end
    checks++; if (dat1 !== exp_dat1) begin errors++; $display("FAIL rd37_dat: got %h expected %h", dat1, exp_dat1); end
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rd37_ack_pulse: got %b expected 0", ack1); end
  endtask

  task automatic test_write_read;
    cyc = 1; stb = 1; we = 1; adr = 8'h12; wdat = 16'hBEEF;
    model1[8'h12] = 16'hBEEF;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL wr12_ack: got %b expected 1", ack1); end
    checks++; if (dat1 !== exp_dat1) begin errors++; $display("FAIL wr12_dat_hold: got %h expected %h", dat1, exp_dat1); end
    we = 0;
    exp_dat1 = model1[8'h12];
    @(negedge clk);
    bus_idle();
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL rd12_ack: got %b expected 1", ack1); end
    checks++; if (dat1 !== 16'hBEEF) begin errors++; $display("FAIL rd12_dat: got %h expected beef", dat1); end
  endtask

  task automatic test_pipelined;
    cyc = 1; stb = 1;
    for (int i = 0; i < 8; i++) begin
      we   = (i < 4);
      adr  = 8'(i % 4);
      wdat = 16'h00A0 + 16'(i % 4);
      if (i < 4) model1[i] = wdat;
      else exp_dat1 = model1[i - 4];
      @(negedge clk);
      checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL pipe_ack[%0d]: got %b expected 1", i, ack1); end
      if (i >= 4) begin
        checks++;
        if (dat1 !== 16'h00A0 + 16'(i - 4)) begin errors++; $display("FAIL pipe_dat[%0d]: got %h expected %h", i - 4, dat1, 16'h00A0 + 16'(i - 4)); end
      end
    end
    bus_idle();
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL pipe_ack_end: got %b expected 0", ack1); end
    checks++; if (dat1 !== 16'h00A3) begin errors++; $display("FAIL pipe_dat_hold: got %h expected 00a3", dat1); end
  endtask

  task automatic test_random;
    logic e_ack, c, s, w;
    logic [7:0]  a;
    logic [15:0] d;
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(3) != 0);
      s = ($urandom_range(2) != 0);
      w = 1'($urandom_range(1));
      a = 8'($urandom);
      d = 16'($urandom);
      cyc = c; stb = s; we = w; adr = a; wdat = d;
      e_ack = c & s;
      if (e_ack) begin
        if (w) model1[a] = d;
        else exp_dat1 = model1[a];
      end
      @(negedge clk);
      checks++; if (ack1 !== e_ack) begin errors++; $display("FAIL rand_ack[%0d]: got %b expected %b", i, ack1, e_ack); end
      checks++; if (dat1 !== exp_dat1) begin errors++; $display("FAIL rand_dat[%0d]: got %h expected %h", i, dat1, exp_dat1); end
      checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL rand_stall[%0d]: got %b expected 0", i, stall1); end
    end
    bus_idle();
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rand_ack_end: got %b expected 0", ack1); end
  endtask

  task automatic test_clear_with_accept;
    int n1, n2;
    cyc = 1; stb = 1; we = 1; adr = 8'h05; wdat = 16'h1234;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL wr05_ack: got %b expected 1", ack1); end
    adr = 8'h06; wdat = 16'($urandom) | 16'h0001; clear_req = 1;
    @(negedge clk);
    bus_idle();
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL clr_accept_ack: got %b expected 1", ack1); end
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL clr_stall_start: got %b expected 1", stall1); end
    count_sweep(n1, n2, 50);
    checks++; if (n1 != 256) begin errors++; $display("FAIL clr_sweep_len: got %0d expected 256", n1); end
    checks++; if (n2 != 200) begin errors++; $display("FAIL clr_sweep_len2: got %0d expected 200", n2); end
    clear_models();
    cyc = 1; stb = 1; we = 0; adr = 8'h05;
    @(negedge clk);
    adr = 8'h06;
    checks++; if (ack1 !== 1'b1 || dat1 !== 16'h0) begin errors++; $display("FAIL clr_rd05: ack %b dat %h expected 1/0000", ack1, dat1); end
    @(negedge clk);
    bus_idle();
    checks++; if (ack1 !== 1'b1 || dat1 !== 16'h0) begin errors++; $display("FAIL clr_rd06: ack %b dat %h expected 1/0000", ack1, dat1); end
    exp_dat1 = 16'h0;
  endtask

  task automatic test_reset_mid;
    int n1, n2;
    cyc = 1; stb = 1; we = 1; adr = 8'h20; wdat = 16'h5A5A;
    @(negedge clk);
    we = 0;
    @(negedge clk);
    checks++; if (dat1 !== 16'h5A5A) begin errors++; $display("FAIL rm_rd20: got %h expected 5a5a", dat1); end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (ack1 !== 1'b0 || dat1 !== 16'h0 || stall1 !== 1'b1) begin errors++; $display("FAIL rm_txn_reset: ack %b dat %h stall %b expected 0/0000/1", ack1, dat1, stall1); end
    bus_idle();
    @(negedge clk);
    rst_n = 1;
    count_sweep(n1, n2, -1);
    checks++; if (n1 != 256) begin errors++; $display("FAIL rm_txn_sweep_len: got %0d expected 256", n1); end
    cyc = 1; stb = 1; we = 1; adr = 8'h20; wdat = 16'h5A5A;
    @(negedge clk);
    we = 0;
    @(negedge clk);
    bus_idle();
    checks++; if (dat1 !== 16'h5A5A) begin errors++; $display("FAIL rm_rd20b: got %h expected 5a5a", dat1); end
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    repeat (99) @(negedge clk);
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL rm_mid_stall: got %b expected 1", stall1); end
    rst_n = 0;
    #1;
    checks++; if (ack1 !== 1'b0 || dat1 !== 16'h0 || stall1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL rm_sweep_reset: ack %b dat %h stall %b busy %b expected 0/0000/1/1", ack1, dat1, stall1, busy1); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    count_sweep(n1, n2, -1);
    checks++; if (n1 != 256) begin errors++; $display("FAIL rm_sweep_len: got %0d expected 256", n1); end
    checks++; if (n2 != 200) begin errors++; $display("FAIL rm_sweep_len2: got %0d expected 200", n2); end
    clear_models();
    exp_dat1 = 16'h0; exp_dat2 = 16'h0;
    cyc = 1; stb = 1; we = 0; adr = 8'h20;
    @(negedge clk);
    bus_idle();
    checks++; if (ack1 !== 1'b1 || dat1 !== 16'h0) begin errors++; $display("FAIL rm_rd20_cleared: ack %b dat %h expected 1/0000", ack1, dat1); end
  endtask

  task automatic test_out_of_range;
    logic        q_we  [$];
    logic [7:0]  q_adr [$];
    logic [15:0] q_dat [$];
    logic        e_ack, e_err;
    int n;
    for (int i = 0; i < 200; i++) begin q_we.push_back(1); q_adr.push_back(8'(i)); q_dat.push_back(16'($urandom) | 16'h8000); end
    q_we.push_back(0); q_adr.push_back(8'h00); q_dat.push_back(16'h0);
    q_we.push_back(1); q_adr.push_back(8'hF0); q_dat.push_back(16'hDEAD);
    q_we.push_back(0); q_adr.push_back(8'hF0); q_dat.push_back(16'h0);
    for (int i = 0; i < 6; i++) begin
      q_we.push_back(1'($urandom_range(1))); q_adr.push_back(8'(200 + $urandom_range(55))); q_dat.push_back(16'($urandom));
    end
    q_we.push_back(0); q_adr.push_back(8'd199); q_dat.push_back(16'h0);
    q_we.push_back(0); q_adr.push_back(8'd200); q_dat.push_back(16'h0);
    for (int i = 0; i < 200; i++) begin q_we.push_back(0); q_adr.push_back(8'(i)); q_dat.push_back(16'h0); end
    n = q_we.size();
    e_ack = 0; e_err = 0;
    cyc2 = 1; stb2 = 1;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        checks++; if (ack2 !== e_ack) begin errors++; $display("FAIL oor_ack[%0d] adr %h: got %b expected %b", i - 1, q_adr[i-1], ack2, e_ack); end
        checks++; if (dat2 !== exp_dat2) begin errors++; $display("FAIL oor_dat[%0d] adr %h: got %h expected %h", i - 1, q_adr[i-1], dat2, exp_dat2); end
`ifdef BOARD_MEM_ERR_EN
        checks++; if (err2 !== e_err) begin errors++; $display("FAIL oor_err[%0d] adr %h: got %b expected %b", i - 1, q_adr[i-1], err2, e_err); end
`endif
      end
      if (i < n) begin
        we = q_we[i]; adr = q_adr[i]; wdat = q_dat[i];
        if (q_adr[i] < 8'd200) begin
          e_ack = 1; e_err = 0;
          if (q_we[i]) model2[q_adr[i]] = q_dat[i];
          else exp_dat2 = model2[q_adr[i]];
        end else begin
`ifdef BOARD_MEM_ERR_EN
          e_ack = 0; e_err = 1;
`else
          e_ack = 1; e_err = 0;
          if (!q_we[i]) exp_dat2 = 16'h0;
`endif
        end
        @(negedge clk);
      end
    end
    bus_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_pipelined();
    test_random();
    test_clear_with_accept();
    test_reset_mid();
    test_out_of_range();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
